// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one registered ALU between NUM_REQ requesters.
// A round-robin pick in IDLE latches one request into the ALU input registers.
// EXEC then waits out the ALU latency, and RESP holds the result until the owner takes it.
module alu_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [7*NUM_REQ-1:0]        req_opcode,
  input  logic [7*NUM_REQ-1:0]        req_func7,
  input  logic [3*NUM_REQ-1:0]        req_func3,
  input  logic [DATA_W*NUM_REQ-1:0]   req_op1,
  input  logic [DATA_W*NUM_REQ-1:0]   req_op2,
  output logic [6:0]                  alu_opcode,
  output logic [6:0]                  alu_func7,
  output logic [2:0]                  alu_func3,
  output logic [DATA_W-1:0]           alu_op1,
  output logic [DATA_W-1:0]           alu_op2,
  input  logic [DATA_W-1:0]           alu_out,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [6:0]          alu_opcode_q, alu_opcode_d;
  logic [6:0]          alu_func7_q, alu_func7_d;
  logic [2:0]          alu_func3_q, alu_func3_d;
  logic [DATA_W-1:0]   alu_op1_q, alu_op1_d;
  logic [DATA_W-1:0]   alu_op2_q, alu_op2_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic [NUM_REQ-1:0]  resp_valid_q, resp_valid_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [6:0]          sel_opcode;
  logic [6:0]          sel_func7;
  logic [2:0]          sel_func3;
  logic [DATA_W-1:0]   sel_op1;
  logic [DATA_W-1:0]   sel_op2;

  // Round-robin search: first valid requester starting just after the last winner, wrapping.
  always_comb begin
    int cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant_q) + k) % NUM_REQ;
      if (!grant_found && req_valid[IDX_W'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
  end

  // Steer the winning requester's packed slice onto the operand capture bus.
  always_comb begin
    sel_opcode = '0;
    sel_func7  = '0;
    sel_func3  = '0;
    sel_op1    = '0;
    sel_op2    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_opcode = req_opcode[i*7 +: 7];
        sel_func7  = req_func7[i*7 +: 7];
        sel_func3  = req_func3[i*3 +: 3];
        sel_op1    = req_op1[i*DATA_W +: DATA_W];
        sel_op2    = req_op2[i*DATA_W +: DATA_W];
      end
    end
  end

  // Accept handshake is combinational and only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state_q == IDLE && grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Next-state logic: issue in IDLE, count out the ALU latency in EXEC, hold the result in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_func7_d  = alu_func7_q;
    alu_func3_d  = alu_func3_q;
    alu_op1_d    = alu_op1_q;
    alu_op2_d    = alu_op2_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          alu_opcode_d = sel_opcode;
          alu_func7_d  = sel_func7;
          alu_func3_d  = sel_func3;
          alu_op1_d    = sel_op1;
          alu_op2_d    = sel_op2;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          cnt_d        = '0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == CNT_W'(ALU_LAT)) begin
          resp_data_d           = alu_out;
          resp_valid_d          = '0;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready[owner_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = '0;
      end
    endcase
  end

  // State and output registers; reset discards any operation in flight and points the pointer at requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      alu_opcode_q <= '0;
      alu_func7_q  <= '0;
      alu_func3_q  <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_func7_q  <= alu_func7_d;
      alu_func3_q  <= alu_func3_d;
      alu_op1_q    <= alu_op1_d;
      alu_op2_q    <= alu_op2_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign alu_opcode = alu_opcode_q;
  assign alu_func7  = alu_func7_q;
  assign alu_func3  = alu_func3_q;
  assign alu_op1    = alu_op1_q;
  assign alu_op2    = alu_op2_q;
  assign resp_data  = resp_data_q;
  assign resp_valid = resp_valid_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single registered ALU (ADD/SUB/AND/OR/XOR, R-type encoding) between NUM_REQ requesters, e.g. multiple issue ports or a test/debug port.
- Picks one request round-robin, drives the ALU operand/control inputs from internal registers, and waits out the ALU's registered latency.
- Returns the result to the winning requester over a valid/ready response handshake.
- One operation is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width.
- ALU_LAT, 1, ALU output register latency in cycles (1..4).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- req_opcode  in  7*NUM_REQ  packed; slice i = bits [7i+6:7i].
- req_func7  in  7*NUM_REQ  packed, same slicing.
- req_func3  in  3*NUM_REQ  packed.
- req_op1  in  DATA_W*NUM_REQ  packed.
- req_op2  in  DATA_W*NUM_REQ  packed.
- alu_opcode  out  7  to ALU OPCODE.
- alu_func7  out  7  to ALU FUNC7.
- alu_func3  out  3  to ALU FUNC3.
- alu_op1  out  DATA_W  to ALU OP1.
- alu_op2  out  DATA_W  to ALU OP2.
- alu_out  in  DATA_W  from ALU OUT.
- resp_valid  out  NUM_REQ  one-hot result valid to the owning requester.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_data  out  DATA_W  result, shared bus, meaningful only with resp_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst high at a clock edge):
  - state goes to IDLE.
  - alu_* registers and resp_data clear to 0.
  - resp_valid clears to 0.
  - last_grant is set to NUM_REQ-1, so requester 0 wins first.
  - Any in-flight operation is discarded; no response is produced for it.
  - rst overrides every other event in the same cycle.
- State machine, states IDLE, EXEC, RESP:
  - IDLE:
    - If any req_valid is high, grant g = first set bit searching from (last_grant+1) mod NUM_REQ upward, wrapping.
    - req_ready[g] is combinational, high in this cycle only; the handshake completes here.
    - At the clock edge: latch slice g of opcode/func7/func3/op1/op2 into the alu_* registers; last_grant <= g; owner <= g; cnt <= 0; go to EXEC.
    - If no req_valid is high, stay in IDLE; all req_ready are 0.
  - EXEC:
    - Lasts exactly ALU_LAT+1 cycles, counted by cnt.
    - In the final cycle (cnt == ALU_LAT): resp_data <= alu_out, resp_valid[owner] <= 1, go to RESP.
    - alu_* outputs are held stable throughout EXEC.
  - RESP:
    - resp_valid[owner] and resp_data are held stable until resp_ready[owner] is high.
    - On that handshake edge: resp_valid <= 0, go to IDLE.
    - resp_ready bits of non-owners are ignored.
- req_ready is all-zero in EXEC and RESP and during rst.
- Latency: request accepted in cycle t gives resp_valid high from cycle t+ALU_LAT+2. For ALU_LAT=1 that is t+3.
- Peak throughput: one operation per ALU_LAT+3 cycles. IDLE always spends at least one cycle between operations.
- The ALU result is passed through unmodified:
  - unsupported encodings return 0 (the ALU's default);
  - arithmetic wraps modulo 2^DATA_W;
  - no decode or checking is done in this block.
- alu_* outputs retain the last issued operation while in IDLE; no toggling when idle.
- Dropping req_valid in a non-granted cycle is legal and has no effect.
- If resp_ready is held low indefinitely, the block stalls in RESP; no new requests are accepted.

Test Plan:
- Single request:
  - Stimulus: req 0, opcode 0110011, f7 0000000, f3 000, op1 5, op2 7 at cycle t, ALU_LAT=1, resp_ready=1.
  - Response: req_ready=0001 at t; alu_op1=5, alu_op2=7 from t+1; resp_valid=0001, resp_data=12 at t+3; IDLE at t+4.
- All four requesters valid continuously, each with ADD of op1=i and op2=100:
  - Grant order 0,1,2,3,0.
  - resp_data 100,101,102,103,100 on the matching one-hot resp_valid.
  - Consecutive grants are 4 cycles apart.
- Backpressure:
  - Stimulus: req 2 SUB (f7 0100000) op1=10, op2=3; resp_ready[2]=0 for 5 cycles while req 0 is valid.
  - Response: resp_valid=0100 and resp_data=7 stable all 5 cycles; req_ready stays 0000; req 0 is granted only after resp_ready[2] rises.
- Wrap and unsupported op:
  - SUB op1=0, op2=1 gives resp_data=FFFFFFFF.
  - f3=001 (SLL encoding) with op1=1, op2=1 gives resp_data=0.
- Reset mid-operation:
  - Stimulus: rst high for one cycle during EXEC of a req 1 operation.
  - Response: next cycle busy=0 and resp_valid=0000; no response for req 1; with req 0 and req 1 both valid afterwards, req 0 is granted first.
- Round-robin skip:
  - Stimulus: only reqs 1 and 3 valid, last_grant=3.
  - Response: grant 1, then 3, then 1; reqs 0 and 2 never get req_ready.
